// File: rtl/itrx_aib_phy_clk_mux_sel_ctl_if.sv
// Select-request and MUX/gate control bundle between the requester and the
// clock MUX select sequencer.
interface itrx_aib_phy_clk_mux_sel_ctl_if;
  logic sel_req;
  logic msel;
  logic clk_gate_en;
  logic busy;
  logic sw_done;

  modport master (
    output sel_req,
    input  msel,
    input  clk_gate_en,
    input  busy,
    input  sw_done
  );

  modport slave (
    input  sel_req,
    output msel,
    output clk_gate_en,
    output busy,
    output sw_done
  );
endinterface

// File: rtl/itrx_aib_phy_clk_mux_sel_ctl.sv
// Glitch-safe clock MUX select sequencer: gate off, switch select, re-enable,
// settle. Also holds a small checker for the gate-low-at-switch invariant.
module itrx_aib_phy_clk_mux_sel_ctl #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 8,
  parameter int   OFF_CYC     = 4,
  parameter int   SW_CYC      = 2,
  parameter int   ON_CYC      = 3,
  parameter logic RST_SEL     = 1'b0
) (
  input logic                         clk,
  input logic                         rst_n,
  itrx_aib_phy_clk_mux_sel_ctl_if.slave bus
);

  function automatic int clamp_cyc(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  localparam int OFF_N = clamp_cyc(OFF_CYC);
  localparam int SW_N  = clamp_cyc(SW_CYC);
  localparam int ON_N  = clamp_cyc(ON_CYC);

  localparam logic [CNT_W-1:0] OFF_LD  = CNT_W'(OFF_N - 1);
  localparam logic [CNT_W-1:0] SW_LD   = CNT_W'(SW_N - 1);
  localparam logic [CNT_W-1:0] ON_LD   = CNT_W'(ON_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_GATE_OFF = 3'd2;
  localparam logic [2:0] ST_SWITCH   = 3'd3;
  localparam logic [2:0] ST_GATE_ON  = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   msel_q, msel_d;
  logic                   gate_q, gate_d;
  logic                   busy_q, busy_d;
  logic                   sw_done_q, sw_done_d;
  logic                   sel_s;
  logic                   cnt_zero_s;

  assign sel_s      = sync_q[SYNC_STAGES-1];
  assign cnt_zero_s = (cnt_q == CNT_ZERO);

  // Synchronizer shift toward sel_s.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.sel_req};
  end

  // Sequencer next state; INIT counts up from its reset value of zero, the
  // switch phases count down from their load value and exit at zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    msel_d    = msel_q;
    gate_d    = gate_q;
    sw_done_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        gate_d = 1'b0;
        if (cnt_q >= ON_LD) begin
          state_d = ST_IDLE;
          gate_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_IDLE: begin
        gate_d = 1'b1;
        if (sel_s != msel_q) begin
          state_d = ST_GATE_OFF;
          gate_d  = 1'b0;
          cnt_d   = OFF_LD;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ST_GATE_OFF: begin
        gate_d = 1'b0;
        if (cnt_zero_s) begin
          msel_d  = sel_s;
          state_d = ST_SWITCH;
          cnt_d   = SW_LD;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_SWITCH: begin
        gate_d = 1'b0;
        if (cnt_zero_s) begin
          gate_d  = 1'b1;
          state_d = ST_GATE_ON;
          cnt_d   = ON_LD;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_GATE_ON: begin
        gate_d = 1'b1;
        if (cnt_zero_s) begin
          state_d   = ST_IDLE;
          sw_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = CNT_ZERO;
        gate_d  = 1'b0;
        msel_d  = msel_q;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter, synchronizer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {SYNC_STAGES{RST_SEL}};
      state_q   <= ST_INIT;
      cnt_q     <= CNT_ZERO;
      msel_q    <= RST_SEL;
      gate_q    <= 1'b0;
      busy_q    <= 1'b1;
      sw_done_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      msel_q    <= msel_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      sw_done_q <= sw_done_d;
    end
  end

  assign bus.msel        = msel_q;
  assign bus.clk_gate_en = gate_q;
  assign bus.busy        = busy_q;
  assign bus.sw_done     = sw_done_q;

endmodule

// The select may only move while the gates are low on both sides of the edge.
module itrx_aib_phy_clk_mux_sel_ctl_chk (
  input logic clk,
  input logic rst_n,
  input logic msel,
  input logic clk_gate_en
);
  msel_change_gated_a: assert property (
    @(posedge clk) disable iff (!rst_n)
    $changed(msel) |-> (!clk_gate_en && !$past(clk_gate_en))
  );
endmodule
